// File: rtl/pipe_stage_buffer.sv
// Two-entry valid/ready skid buffer with a rewritable sideband field; 1-cycle latency, in_ready from registered state only.
// Optional zero-latency pass-through when empty: define PIPE_STAGE_BYPASS_EN.
module pipe_stage_buffer #(
   parameter int DATA_W = 64,
   parameter int SIDE_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SIDE_W-1:0] in_side,
   input  logic              side_load,
   input  logic [SIDE_W-1:0] side_upd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SIDE_W-1:0] out_side,
   output logic [1:0]        occupancy
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [SIDE_W-1:0] main_side_q,  main_side_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [SIDE_W-1:0] skid_side_q,  skid_side_d;

   logic push;
   logic pop;

   assign in_ready  = ~skid_valid_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_BYPASS_EN
   logic bypass;
   // Empty buffer presents the upstream entry directly; flush blanks it.
   assign bypass    = ~main_valid_q & ~skid_valid_q & ~flush;
   assign out_valid = main_valid_q | (bypass & in_valid);
   assign out_data  = main_valid_q ? main_data_q : (bypass ? in_data : main_data_q);
   assign out_side  = main_valid_q ? main_side_q : (bypass ? in_side : main_side_q);
`else
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_side  = main_side_q;
`endif

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_side_d  = main_side_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_side_d  = skid_side_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_data_d  = '0;
         main_side_d  = '0;
         skid_valid_d = 1'b0;
         skid_data_d  = '0;
         skid_side_d  = '0;
      end else begin
         case ({main_valid_q, skid_valid_q})
            2'b00: begin
               // A pop while empty can only be a bypassed entry, which is not stored.
               if (push && !pop) begin
                  main_valid_d = 1'b1;
                  main_data_d  = in_data;
                  main_side_d  = in_side;
               end
            end
            2'b10: begin
               if (side_load && !pop) main_side_d = side_upd;
               if (pop && push) begin
                  main_data_d = in_data;
                  main_side_d = in_side;
               end else if (pop) begin
                  main_valid_d = 1'b0;
               end else if (push) begin
                  skid_valid_d = 1'b1;
                  skid_data_d  = in_data;
                  skid_side_d  = in_side;
               end
            end
            2'b11: begin
               if (pop) begin
                  main_data_d  = skid_data_q;
                  main_side_d  = skid_side_q;
                  skid_valid_d = 1'b0;
               end else if (side_load) begin
                  main_side_d = side_upd;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_side_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_side_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_side_q  <= main_side_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_side_q  <= skid_side_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: directed scenarios followed by random traffic.
module tb_pipe_stage_buffer;
   localparam int DW = 64;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [SW-1:0] in_side;
   logic          side_load;
   logic [SW-1:0] side_upd;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [SW-1:0] out_side;
   logic [1:0]    occupancy;

   pipe_stage_buffer #(.DATA_W(DW), .SIDE_W(SW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_side(in_side),
      .side_load(side_load), .side_upd(side_upd), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_side(out_side),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
   } ent_t;

   ent_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Inputs are driven at posedge+1; outputs are sampled at the falling edge.
   task automatic tick();
      int   n;
      logic pop;
      logic ev;
      ent_t e;
      #4;
      n  = sb.size();
      ev = 1'b0;
`ifdef PIPE_STAGE_BYPASS_EN
      if (n == 0 && in_valid && !flush) ev = 1'b1;
`endif
      check("occupancy", 64'(occupancy), 64'(n));
      check("in_ready", 64'(in_ready), 64'(n < 2));
      check("out_valid", 64'(out_valid), 64'((n > 0) || ev));
      if (n > 0) begin
         check("out_data", out_data, sb[0].d);
         check("out_side", 64'(out_side), 64'(sb[0].s));
      end else if (ev) begin
         check("byp_data", out_data, in_data);
         check("byp_side", 64'(out_side), 64'(in_side));
      end
      if (flush) begin
         sb.delete();
      end else begin
         pop = (n > 0 || ev) && out_ready;
         if (side_load && n > 0 && !pop) begin
            e = sb[0];
            e.s = side_upd;
            sb[0] = e;
         end
         if (pop && n > 0) void'(sb.pop_front());
         if (in_valid && n < 2 && !(ev && out_ready)) begin
            e.d = in_data;
            e.s = in_side;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s);
      in_valid = v;
      in_data  = d;
      in_side  = s;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_side = '0;
      side_load = 1'b0; side_upd = '0; flush = 1'b0; out_ready = 1'b0;
      #12 reset = 1'b0;
      @(posedge clk); #1;
      check("rst_out_data", out_data, 64'h0);
      check("rst_out_side", 64'(out_side), 64'h0);
      tick();

      // Single entry, 1-cycle latency, then drains.
      out_ready = 1'b1;
      drive(1'b1, 64'h1234, 3'b010); tick();
      drive(1'b0, 64'h0, 3'b000);    tick();
      tick();

      // Fill both entries, then drain in order.
      out_ready = 1'b0;
      drive(1'b1, 64'h11, 3'b001); tick();
      drive(1'b1, 64'h22, 3'b011); tick();
      drive(1'b0, 64'h0, 3'b000);  tick();
      out_ready = 1'b1; tick(); tick(); tick();

      // Simultaneous pop and push replaces the head.
      out_ready = 1'b0;
      drive(1'b1, 64'hAA, 3'b110); tick();
      out_ready = 1'b1;
      drive(1'b1, 64'h33, 3'b101); tick();
      drive(1'b0, 64'h0, 3'b000);
      out_ready = 1'b0; tick();
      out_ready = 1'b1; tick(); tick();

      // Sideband rewrite on a held head, then dropped when the head pops.
      out_ready = 1'b0;
      drive(1'b1, 64'hA0, 3'b000); tick();
      drive(1'b0, 64'h0, 3'b000);
      side_load = 1'b1; side_upd = 3'b100; tick();
      side_load = 1'b0; tick();
      drive(1'b1, 64'hB0, 3'b101); tick();
      drive(1'b0, 64'h0, 3'b000);
      out_ready = 1'b1; side_load = 1'b1; side_upd = 3'b111; tick();
      side_load = 1'b0; out_ready = 1'b0; tick();
      out_ready = 1'b1; tick(); tick();

      // Flush from full with a concurrent push.
      out_ready = 1'b0;
      drive(1'b1, 64'h51, 3'b001); tick();
      drive(1'b1, 64'h52, 3'b010); tick();
      drive(1'b1, 64'h53, 3'b011); flush = 1'b1; tick();
      drive(1'b0, 64'h0, 3'b000);  flush = 1'b0;
      check("flush_out_data", out_data, 64'h0);
      check("flush_out_side", 64'(out_side), 64'h0);
      tick();

      // Asynchronous reset between clock edges.
      drive(1'b1, 64'h77, 3'b111); tick();
      drive(1'b0, 64'h0, 3'b000); tick();
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'h0);
      check("arst_in_ready", 64'(in_ready), 64'h1);
      check("arst_occupancy", 64'(occupancy), 64'h0);
      check("arst_out_data", out_data, 64'h0);
      reset = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      tick();

`ifdef PIPE_STAGE_BYPASS_EN
      out_ready = 1'b1;
      drive(1'b1, 64'hBEEF, 3'b011); tick();
      drive(1'b0, 64'h0, 3'b000); tick();
`endif

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 3'($urandom));
         out_ready = 1'($urandom_range(0, 2) != 0);
         side_load = ($urandom_range(0, 3) == 0);
         side_upd  = 3'($urandom);
         flush     = ($urandom_range(0, 19) == 0);
         tick();
      end
      drive(1'b0, 64'h0, 3'b000);
      side_load = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised successor to the fixed-field pipeline stage registers between pipeline stages.
- Carries one generic payload bus plus a late-updatable sideband field (the nzp / branch-enable class of signal).
- Replaces bare load/stall control with a valid/ready handshake backed by a 2-entry skid buffer, plus a flush input.
- in_ready is a function of registered state only, so stall does not propagate combinationally between stages.

Parameters:
DATA_W, 64, payload width in bits (control word, pc, alu, dr, and similar fields packed by the instantiating stage)
SIDE_W, 3, width of the sideband field that can be rewritten while the entry is held
Both parameters >= 1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  upstream entry present
in_ready  output  1  buffer can accept; equals !skid_valid (registered state only)
in_data  input  DATA_W  upstream payload
in_side  input  SIDE_W  upstream sideband value for the incoming entry
side_load  input  1  rewrite sideband of the held head entry
side_upd  input  SIDE_W  value written by side_load
flush  input  1  discard all held entries
out_valid  output  1  head entry present
out_ready  input  1  downstream accepts head
out_data  output  DATA_W  head payload
out_side  output  SIDE_W  head sideband
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Storage: main entry (head) {main_valid, main_data, main_side}; skid entry {skid_valid, skid_data, skid_side}.
- Outputs: out_valid = main_valid; out_data = main_data; out_side = main_side; occupancy = main_valid + skid_valid.
- Reset (async, active-high): all valids = 0; all data and side registers = 0. Immediately after reset: out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0, out_side = 0.
- Events per cycle: push = in_valid & in_ready; pop = out_valid & out_ready.
- flush has top priority. Next cycle: both valids = 0 and data/side = 0. A push in the same cycle completes the handshake but the entry is discarded. side_load is ignored.
- Otherwise, update by state (main_valid, skid_valid):
  - Empty (0,0): push loads main. Latency in->out is 1 cycle.
  - Main only (1,0):
    - pop & push: main <= input.
    - pop only: main empties.
    - push only: skid <= input; in_ready drops next cycle.
    - neither: hold.
  - Full (1,1): in_ready = 0, so no push is possible.
    - pop: main <= skid; skid empties.
    - no pop: hold.
  - skid_valid = 1 with main_valid = 0 is illegal and unreachable.
- Ordering: strict FIFO order. The skid entry is never overtaken by a new push.
- side_load (no flush):
  - Held head (out_valid & !pop): main_side <= side_upd. Only the side field changes; payload and valids are untouched.
  - Head pops in the same cycle: ignored.
  - Buffer empty: ignored.
  - Never affects the skid entry or the incoming entry.
- Reset asserted mid-transfer: state clears immediately and asynchronously; in-flight entries are lost.
- No combinational path from out_ready or out_valid to in_ready, except under the optional feature below.

Optional Feature:
- Macro: PIPE_STAGE_BYPASS_EN
- Defined:
  - When both entries are empty, out_valid = in_valid, out_data = in_data, out_side = in_side combinationally.
  - If out_ready is also high, the entry passes through in 0 cycles and is not stored; occupancy stays 0.
  - If out_ready is low, the entry is stored in main as normal.
  - flush suppresses the bypass: out_valid = 0.
- Undefined: minimum latency 1 cycle; outputs strictly registered.

Test Plan:
1. Reset pulse mid-cycle, no clock edge -> out_valid=0, in_ready=1, occupancy=0, out_data=0 immediately.
2. out_ready=1; push in_data=0x1234, in_side=3'b010 -> next cycle out_valid=1, out_data=0x1234, out_side=3'b010; following cycle occupancy=0.
3. out_ready=0; push A=0x11, then B=0x22 -> occupancy=2, in_ready=0. Then out_ready=1 -> A, then B on consecutive cycles; in_ready=1 one cycle after A pops.
4. Main holds A, out_ready=1, push C=0x33 in same cycle -> next cycle out_data=0x33, occupancy=1, skid untouched.
5. Head A held, out_side=3'b000, out_ready=0; side_load=1, side_upd=3'b100 -> out_side=3'b100, out_data still A. Repeat with out_ready=1 -> update dropped and the next head keeps its own side value.
6. Occupancy=2; assert flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0. With PIPE_STAGE_BYPASS_EN: empty, out_ready=1, in_valid=1 -> out_valid=1 in the same cycle, occupancy stays 0.
